res_argmax_reader: RTL and testbench
====================================

# res_argmax_reader

Result-side consumer for the convolution accelerator. It accepts the 10-entry vector of 32-bit signed class scores through a valid/ready handshake and scans it sequentially, one compare per cycle. It then presents the winning class index and its score downstream with a second valid/ready handshake. It sits directly after the accumulator/result register stage and forms the receiving end of the accelerator's result interface.

## Interface
- N_CLASS, 10, number of class scores per result vector
- RES_W, 32, score width in bits, two's-complement signed
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= N_CLASS
- CNT_W, 8, width of the result frame counter
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_pre_valid  in  1  upstream score vector valid
- o_pre_ready  out  1  block can capture a vector this cycle
- i_res  in  [N_CLASS-1:0][RES_W-1:0]  score vector, sampled on handshake only
- o_post_valid  out  1  o_class/o_score valid
- i_post_ready  in  1  downstream accepts result
- o_class  out  IDX_W  index of maximum score
- o_score  out  RES_W  maximum score value
- o_frame_cnt  out  CNT_W  count of completed output handshakes

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- **Input handshake:** fires when i_pre_valid && o_pre_ready.
- **o_pre_ready:** (state==IDLE) || (state==DONE && i_post_ready). It is combinational from state and i_post_ready.
- **Capture:** on input handshake, copy i_res into an internal vector register. Initialise best_score=i_res[0], best_idx=0, scan_idx=1. Go to SCAN.
- **SCAN:** each cycle compare vec[scan_idx] against best_score as signed values.
  - If strictly greater, update best_score and best_idx.
  - Increment scan_idx.
  - After comparing index N_CLASS-1, go to DONE.
- **Tie rule:** strictly-greater compare, so the lowest index wins among equal maxima.
- **DONE:** o_post_valid=1. o_class and o_score hold best_idx and best_score, stable until the output handshake.
- **Output handshake:** fires when o_post_valid && i_post_ready.
  - o_frame_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
  - Next state is IDLE, or SCAN if an input handshake fires in the same cycle.
- **Simultaneous output and input handshake in DONE:** both complete in that cycle. The new vector is captured and the counter increments; no bubble cycle.
- i_res is ignored outside the input handshake. Upstream may change it freely.

## Timing
- **Reset values:** state IDLE, o_post_valid 0, o_class 0, o_score 0, o_frame_cnt 0, internal vector 0. o_pre_ready reads 1 once state is IDLE.
- **Reset mid-operation:** asynchronous and immediate. Any partial scan or pending result is discarded and the counter is cleared.
- **Latency:** input handshake at cycle T. SCAN occupies T+1 .. T+(N_CLASS-1), i.e. T+1..T+9 at the default. o_post_valid rises at T+N_CLASS (T+10).
- **Throughput:** one result per N_CLASS cycles with downstream always ready (back-to-back via the DONE overlap).
- **Backpressure:** o_post_valid stays high and outputs stay frozen for any number of cycles while i_post_ready=0. o_pre_ready stays 0 during that time.
- o_pre_ready is 0 throughout SCAN.

## Structure
- Shared package conv_acc_pkg holds the following, and the block imports them:
  - constants N_CLASS=10, RES_W=32, IDX_W=4
  - typedef res_vec_t (N_CLASS x RES_W logic array)
  - enum argmax_state_e {IDLE, SCAN, DONE}
- Single module; no sub-module is warranted. The compare datapath is one signed comparator plus a mux on scan_idx.

## Test plan
- **Distinct maximum:** reset, then send scores {0:5, 1:-3, 2:100, others 7}. Expect o_class=2, o_score=100 with o_post_valid rising exactly 10 cycles after the input handshake; o_frame_cnt=1 after accept.
- **Negatives and ties:** send all scores -1 except index 4 = index 7 = 0x7FFF_FFF0, and index 0 = 0x8000_0000. Expect o_class=4 (lowest tie wins) and signed compare ignoring index 0.
- **Backpressure:** hold i_post_ready=0 for 20 cycles after o_post_valid. Expect outputs stable and o_pre_ready=0 throughout; release and see one handshake only.
- **Back-to-back:** keep i_pre_valid=1 and i_post_ready=1 with 3 distinct vectors. Expect results every 10 cycles, no bubble, and o_frame_cnt=3.
- **Counter wrap:** run 256 results. Expect o_frame_cnt to go 255 then 0.
- **Reset mid-scan:** assert i_rst low at cycle T+4 of a scan. Expect o_post_valid=0, o_class=0, o_frame_cnt=0 immediately, and a fresh vector after reset producing the correct result.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared definitions for the convolution accelerator result path:
// class-vector geometry, score vector type and the argmax reader state encoding.
package conv_acc_pkg;

   localparam int N_CLASS = 10;
   localparam int RES_W   = 32;
   localparam int IDX_W   = 4;

   typedef logic [N_CLASS-1:0][RES_W-1:0] res_vec_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_e;

endpackage

// File: rtl/res_argmax_reader.sv
// Captures a class-score vector, scans it one signed compare per cycle and
// hands the winning index/score downstream over a valid/ready handshake.
module res_argmax_reader
   import conv_acc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pre_valid,
   output logic             o_pre_ready,
   input  res_vec_t         i_res,
   output logic             o_post_valid,
   input  logic             i_post_ready,
   output logic [IDX_W-1:0] o_class,
   output logic [RES_W-1:0] o_score,
   output logic [CNT_W-1:0] o_frame_cnt
);

   argmax_state_e            state_q, state_d;
   res_vec_t                 vec_q, vec_d;
   logic signed [RES_W-1:0]  best_score_q, best_score_d;
   logic [IDX_W-1:0]         best_idx_q, best_idx_d;
   logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
   logic                     post_valid_q, post_valid_d;

   logic signed [RES_W-1:0]  cand_score;
   logic                     in_hs;
   logic                     out_hs;

   // Ready may look through DONE so a new vector lands in the same cycle the result leaves.
   assign o_pre_ready = (state_q == IDLE) || ((state_q == DONE) && i_post_ready);
   assign in_hs       = i_pre_valid && o_pre_ready;
   assign out_hs      = (state_q == DONE) && i_post_ready;
   assign cand_score  = vec_q[scan_idx_q];

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      scan_idx_d   = scan_idx_q;
      frame_cnt_d  = frame_cnt_q;

      case (state_q)
         SCAN: begin
            // Strictly greater keeps the lowest index among equal maxima.
            if (cand_score > best_score_q) begin
               best_score_d = cand_score;
               best_idx_d   = scan_idx_q;
            end
            scan_idx_d = scan_idx_q + IDX_W'(1);
            if (scan_idx_q == IDX_W'(N_CLASS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_hs) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (in_hs) begin
         vec_d        = i_res;
         best_score_d = i_res[0];
         best_idx_d   = '0;
         scan_idx_d   = IDX_W'(1);
         state_d      = SCAN;
      end

      post_valid_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         scan_idx_q   <= '0;
         frame_cnt_q  <= '0;
         post_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         scan_idx_q   <= scan_idx_d;
         frame_cnt_q  <= frame_cnt_d;
         post_valid_q <= post_valid_d;
      end
   end

   assign o_post_valid = post_valid_q;
   assign o_class      = best_idx_q;
   assign o_score      = best_score_q;
   assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_res_argmax_reader.sv
// Directed bench for res_argmax_reader: table of score vectors with hand-computed
// winners, plus sequences for backpressure, back-to-back, reset mid-scan and counter wrap.
module tb_res_argmax_reader;
   import conv_acc_pkg::*;

   logic             i_clk;
   logic             i_rst;
   logic             i_pre_valid;
   logic             o_pre_ready;
   res_vec_t         i_res;
   logic             o_post_valid;
   logic             i_post_ready;
   logic [IDX_W-1:0] o_class;
   logic [RES_W-1:0] o_score;
   logic [7:0]       o_frame_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] exp_cnt;

   typedef struct {
      res_vec_t    res;
      logic [3:0]  cls;
      logic [31:0] score;
   } vec_rec_t;

   vec_rec_t tbl[6];

   res_argmax_reader #(.CNT_W(8)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pre_valid  (i_pre_valid),
      .o_pre_ready  (o_pre_ready),
      .i_res        (i_res),
      .o_post_valid (o_post_valid),
      .i_post_ready (i_post_ready),
      .o_class      (o_class),
      .o_score      (o_score),
      .o_frame_cnt  (o_frame_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic res_vec_t fill(input logic [31:0] x);
      res_vec_t v;
      for (int i = 0; i < N_CLASS; i++) v[i] = x;
      return v;
   endfunction

   // Call at a negedge; returns #1 after the capturing posedge.
   task automatic send(input res_vec_t v);
      i_res       = v;
      i_pre_valid = 1'b1;
      for (int k = 0; k < 40 && !o_pre_ready; k++) @(negedge i_clk);
      if (!o_pre_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: o_pre_ready stayed 0, expected 1");
      end
      @(posedge i_clk);
      #1 i_pre_valid = 1'b0;
   endtask

   // Counts negedges until o_post_valid; ends at the negedge where it is seen.
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge i_clk);
         lat++;
      end while (!o_post_valid && lat < 40);
      if (!o_post_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL valid_timeout: o_post_valid stayed 0 after %0d cycles, expected 1", lat);
      end
   endtask

   task automatic accept();
      i_post_ready = 1'b1;
      @(posedge i_clk);
      #1 i_post_ready = 1'b0;
      @(negedge i_clk);
   endtask

   initial begin
      int lat;
      logic [3:0]  hold_cls;
      logic [31:0] hold_score;

      tbl[0].res = fill(32'd7);
      tbl[0].res[0] = 32'd5; tbl[0].res[1] = 32'hFFFF_FFFD; tbl[0].res[2] = 32'd100;
      tbl[0].cls = 4'd2; tbl[0].score = 32'd100;

      tbl[1].res = fill(32'hFFFF_FFFF);
      tbl[1].res[4] = 32'h7FFF_FFF0; tbl[1].res[7] = 32'h7FFF_FFF0; tbl[1].res[0] = 32'h8000_0000;
      tbl[1].cls = 4'd4; tbl[1].score = 32'h7FFF_FFF0;

      tbl[2].res = fill(32'h1234_5678);
      tbl[2].cls = 4'd0; tbl[2].score = 32'h1234_5678;

      tbl[3].res = fill(32'hFFFF_FFFB);
      tbl[3].res[9] = 32'hFFFF_FFFE;
      tbl[3].cls = 4'd9; tbl[3].score = 32'hFFFF_FFFE;

      tbl[4].res = fill(32'd1);
      tbl[4].res[0] = 32'h7FFF_FFFF; tbl[4].res[5] = 32'h8000_0000;
      tbl[4].cls = 4'd0; tbl[4].score = 32'h7FFF_FFFF;

      tbl[5].res = fill(32'hFFFF_FF9C);
      tbl[5].res[3] = 32'h8000_0000; tbl[5].res[6] = 32'hFFFF_FF9D;
      tbl[5].cls = 4'd6; tbl[5].score = 32'hFFFF_FF9D;

      i_rst        = 1'b0;
      i_pre_valid  = 1'b0;
      i_post_ready = 1'b0;
      i_res        = fill(32'hDEAD_BEEF);
      exp_cnt      = 8'd0;

      repeat (3) @(negedge i_clk);
      chk("rst_valid", 32'(o_post_valid), 32'd0);
      chk("rst_class", 32'(o_class), 32'd0);
      chk("rst_score", o_score, 32'd0);
      chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
      chk("rst_pre_ready", 32'(o_pre_ready), 32'd1);
      i_rst = 1'b1;
      @(negedge i_clk);

      for (int t = 0; t < 6; t++) begin
         send(tbl[t].res);
         chk("scan_pre_ready", 32'(o_pre_ready), 32'd0);
         wait_valid(lat);
         chk("latency", 32'(lat), 32'd10);
         chk("class", 32'(o_class), 32'(tbl[t].cls));
         chk("score", o_score, tbl[t].score);
         chk("done_pre_ready", 32'(o_pre_ready), 32'd0);
         accept();
         exp_cnt++;
         chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
         chk("valid_drop", 32'(o_post_valid), 32'd0);
      end

      // Backpressure: result must hold for 20 cycles, then exactly one handshake.
      send(tbl[0].res);
      wait_valid(lat);
      hold_cls   = o_class;
      hold_score = o_score;
      chk("bp_class0", 32'(hold_cls), 32'd2);
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         chk("bp_valid", 32'(o_post_valid), 32'd1);
         chk("bp_class", 32'(o_class), 32'(hold_cls));
         chk("bp_score", o_score, hold_score);
         chk("bp_pre_ready", 32'(o_pre_ready), 32'd0);
      end
      accept();
      exp_cnt++;
      chk("bp_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      chk("bp_valid_drop", 32'(o_post_valid), 32'd0);
      repeat (3) @(negedge i_clk);
      chk("bp_cnt_hold", 32'(o_frame_cnt), 32'(exp_cnt));

      // Back-to-back: three vectors with both sides always ready.
      i_post_ready = 1'b1;
      i_res        = tbl[0].res;
      i_pre_valid  = 1'b1;
      @(posedge i_clk);
      #1 i_res = tbl[1].res;
      for (int r = 0; r < 3; r++) begin
         wait_valid(lat);
         chk("b2b_latency", 32'(lat), 32'd10);
         chk("b2b_class", 32'(o_class), 32'(tbl[r].cls));
         chk("b2b_score", o_score, tbl[r].score);
         if (r == 2) i_pre_valid = 1'b0;
         @(posedge i_clk);
         #1;
         if (r == 0) i_res = tbl[2].res;
      end
      i_post_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd3;
      @(negedge i_clk);
      chk("b2b_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      chk("b2b_valid_drop", 32'(o_post_valid), 32'd0);
      chk("b2b_idle_ready", 32'(o_pre_ready), 32'd1);

      // Reset four cycles into a scan.
      send(tbl[0].res);
      repeat (3) @(posedge i_clk);
      #1;
      chk("mid_scan_class", 32'(o_class), 32'd2);
      i_rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(o_post_valid), 32'd0);
      chk("mrst_class", 32'(o_class), 32'd0);
      chk("mrst_score", o_score, 32'd0);
      chk("mrst_cnt", 32'(o_frame_cnt), 32'd0);
      @(negedge i_clk);
      i_rst   = 1'b1;
      exp_cnt = 8'd0;
      @(negedge i_clk);
      send(tbl[3].res);
      wait_valid(lat);
      chk("post_rst_latency", 32'(lat), 32'd10);
      chk("post_rst_class", 32'(o_class), 32'd9);
      chk("post_rst_score", o_score, 32'hFFFF_FFFE);
      accept();
      exp_cnt++;
      chk("post_rst_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

      // Counter wrap: 255 more results take it through 255 and back to 0.
      i_post_ready = 1'b1;
      i_res        = tbl[1].res;
      i_pre_valid  = 1'b1;
      for (int r = 0; r < 255; r++) begin
         wait_valid(lat);
         if (r == 254) i_pre_valid = 1'b0;
         @(posedge i_clk);
         #1;
         exp_cnt++;
         if (exp_cnt == 8'hFF || exp_cnt == 8'h00)
            chk("wrap_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      end
      i_post_ready = 1'b0;
      @(negedge i_clk);
      chk("wrap_final_cnt", 32'(o_frame_cnt), 32'd0);
      chk("wrap_class", 32'(o_class), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
